// File: rtl/morph_fitness_evaluator_if.sv
// Handshake and image bus between the morphologic processor and the fitness evaluator.
// Best-score tracking signals exist only when FITNESS_BEST_TRACK_EN is defined.
interface morph_fitness_evaluator_if #(
  parameter int ImageWidth  = 32,
  parameter int ImageHeight = 32,
  parameter int ScoreWidth  = 11
);
  localparam int Pixels = ImageWidth * ImageHeight;

  logic                  start;
  logic [Pixels-1:0]     image;
  logic [Pixels-1:0]     target;
  logic                  busy;
  logic                  done;
  logic [ScoreWidth-1:0] score;

`ifdef FITNESS_BEST_TRACK_EN
  logic                  clear_best;
  logic [ScoreWidth-1:0] best_score;
  logic                  best_update;

  modport master (
    output start, image, target, clear_best,
    input  busy, done, score, best_score, best_update
  );

  modport slave (
    input  start, image, target, clear_best,
    output busy, done, score, best_score, best_update
  );
`else
  modport master (
    output start, image, target,
    input  busy, done, score
  );

  modport slave (
    input  start, image, target,
    output busy, done, score
  );
`endif
endinterface

// File: rtl/morph_fitness_evaluator.sv
// Hamming-distance scorer: snapshots image^target at start, popcounts one chunk per cycle.
// Optional best-score tracking is enabled with the FITNESS_BEST_TRACK_EN macro.
module morph_fitness_evaluator #(
  parameter int ImageWidth  = 32,
  parameter int ImageHeight = 32,
  parameter int ChunkWidth  = 32,
  parameter int ScoreWidth  = 11
) (
  input logic                     clk,
  input logic                     rst,
  morph_fitness_evaluator_if.slave bus
);
  localparam int Pixels = ImageWidth * ImageHeight;
  localparam int Chunks = Pixels / ChunkWidth;
  localparam int PopW   = $clog2(ChunkWidth + 1);
  localparam int AccW   = $clog2(Pixels + 1);
  localparam int IdxW   = (Chunks > 1) ? $clog2(Chunks) : 1;
  localparam int WideW  = (ScoreWidth > AccW) ? ScoreWidth : AccW;

  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(Chunks - 1);
  localparam logic [WideW-1:0] ScoreMax = WideW'({ScoreWidth{1'b1}});

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t state;
  state_t state_next;

  logic [Chunks-1:0][ChunkWidth-1:0] diff;
  logic [AccW-1:0]       acc;
  logic [IdxW-1:0]       idx;
  logic [PopW-1:0]       pop;
  logic [AccW-1:0]       total;
  logic [WideW-1:0]      total_wide;
  logic [ScoreWidth-1:0] total_sat;
  logic                  load;
  logic                  step;
  logic                  finish;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = COUNT;
      COUNT:   if (idx == LastIdx) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE:  load = bus.start;
      COUNT: begin
        step   = 1'b1;
        finish = (idx == LastIdx);
      end
      default: ;
    endcase
  end

  assign bus.busy = (state == COUNT);

  always_comb begin
    pop = '0;
    for (int i = 0; i < ChunkWidth; i++) pop = pop + PopW'(diff[idx][i]);
  end

  // Clamp rather than wrap when the score port is narrower than the full count.
  assign total      = acc + AccW'(pop);
  assign total_wide = WideW'(total);
  assign total_sat  = (total_wide > ScoreMax) ? '1 : ScoreWidth'(total_wide);

  always_ff @(posedge clk) begin
    if (!rst) begin
      diff      <= '0;
      acc       <= '0;
      idx       <= '0;
      bus.done  <= 1'b0;
      bus.score <= '0;
    end else begin
      bus.done <= finish;
      if (load) begin
        diff <= bus.image ^ bus.target;
        acc  <= '0;
        idx  <= '0;
      end else if (step) begin
        if (finish) begin
          acc       <= '0;
          idx       <= '0;
          bus.score <= total_sat;
        end else begin
          acc <= total;
          idx <= idx + 1'b1;
        end
      end
    end
  end

`ifdef FITNESS_BEST_TRACK_EN
  logic [ScoreWidth-1:0] best_base;

  // A clear on the completing edge applies first, so the new score always wins it.
  assign best_base = bus.clear_best ? '1 : bus.best_score;

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.best_score  <= '1;
      bus.best_update <= 1'b0;
    end else begin
      bus.best_update <= 1'b0;
      if (finish && (total_sat < best_base)) begin
        bus.best_score  <= total_sat;
        bus.best_update <= 1'b1;
      end else begin
        bus.best_score <= best_base;
      end
    end
  end
`endif
endmodule

// File: tb/tb_morph_fitness_evaluator.sv
// Self-checking bench for morph_fitness_evaluator: vector table, random runs against a
// pixel-counting reference model, and hand-written handshake/reset/snapshot sequences.
module tb_morph_fitness_evaluator;
  localparam int ImageWidth  = 32;
  localparam int ImageHeight = 32;
  localparam int ChunkWidth  = 32;
  localparam int ScoreWidth  = 11;
  localparam int Pixels      = ImageWidth * ImageHeight;
  localparam int Chunks      = Pixels / ChunkWidth;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  morph_fitness_evaluator_if #(
    .ImageWidth (ImageWidth),
    .ImageHeight(ImageHeight),
    .ScoreWidth (ScoreWidth)
  ) bus ();

  morph_fitness_evaluator #(
    .ImageWidth (ImageWidth),
    .ImageHeight(ImageHeight),
    .ChunkWidth (ChunkWidth),
    .ScoreWidth (ScoreWidth)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string             name;
    logic [Pixels-1:0] img;
    logic [Pixels-1:0] tgt;
    longint            exp_score;
  } vec_t;

  vec_t vecs[6];

`ifdef FITNESS_BEST_TRACK_EN
  bit clear_on_finish = 1'b0;
  bit upd_seen        = 1'b0;
`endif

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: count differing pixels one by one, then clamp to the score range.
  function automatic longint model_score(input logic [Pixels-1:0] img, input logic [Pixels-1:0] tgt);
    longint cnt = 0;
    longint lim = (longint'(1) << ScoreWidth) - 1;
    for (int p = 0; p < Pixels; p++) if (img[p] != tgt[p]) cnt++;
    return (cnt > lim) ? lim : cnt;
  endfunction

  function automatic logic [Pixels-1:0] rand_image();
    logic [Pixels-1:0] r;
    for (int w = 0; w < Pixels / 32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [Pixels-1:0] low_bits(input int k);
    logic [Pixels-1:0] r = '0;
    for (int p = 0; p < k; p++) r[p] = 1'b1;
    return r;
  endfunction

  task automatic applyStimulus(input logic [Pixels-1:0] img, input logic [Pixels-1:0] tgt,
                               input bit flip, output int lat, output int busy_cnt,
                               output longint sc, output int busy_at_done);
    bus.image  = img;
    bus.target = tgt;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (flip) bus.image = ~img;
    busy_cnt     = bus.busy ? 1 : 0;
    lat          = 0;
    sc           = -1;
    busy_at_done = -1;
    for (int n = 1; n <= Chunks + 8; n++) begin
`ifdef FITNESS_BEST_TRACK_EN
      bus.clear_best = clear_on_finish && (n == Chunks);
`endif
      @(posedge clk); #1;
`ifdef FITNESS_BEST_TRACK_EN
      bus.clear_best = 1'b0;
`endif
      if (bus.done) begin
        lat          = n;
        sc           = longint'(bus.score);
        busy_at_done = int'(bus.busy);
`ifdef FITNESS_BEST_TRACK_EN
        upd_seen = bus.best_update;
`endif
        break;
      end
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic runAndCheck(input string name, input logic [Pixels-1:0] img,
                             input logic [Pixels-1:0] tgt, input bit flip, input longint expected);
    int     lat;
    int     busy_cnt;
    int     busy_at_done;
    longint sc;
    applyStimulus(img, tgt, flip, lat, busy_cnt, sc, busy_at_done);
    checkOutput({name, " latency"}, lat, Chunks);
    checkOutput({name, " busy cycles"}, busy_cnt, Chunks);
    checkOutput({name, " busy in done cycle"}, busy_at_done, 0);
    checkOutput({name, " score"}, sc, expected);
    @(posedge clk); #1;
    checkOutput({name, " done cleared"}, bus.done, 0);
    checkOutput({name, " score held"}, bus.score, expected);
  endtask

  initial begin
    logic [Pixels-1:0] r;
    logic [Pixels-1:0] t;
    logic [Pixels-1:0] img2;
    longint            exp_s;
    int                dones;
    int                done_pos[$];
    longint            done_sc[$];

    bus.start  = 1'b0;
    bus.image  = '0;
    bus.target = '0;
`ifdef FITNESS_BEST_TRACK_EN
    bus.clear_best = 1'b0;
`endif
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset score", bus.score, 0);
`ifdef FITNESS_BEST_TRACK_EN
    checkOutput("reset best_score", bus.best_score, (1 << ScoreWidth) - 1);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

`ifdef FITNESS_BEST_TRACK_EN
    begin
      int ks[4]       = '{5, 3, 7, 3};
      int exp_best[4] = '{5, 3, 3, 3};
      int exp_upd[4]  = '{1, 1, 0, 0};
      for (int j = 0; j < 4; j++) begin
        runAndCheck($sformatf("best run %0d", j), low_bits(ks[j]), '0, 1'b0, ks[j]);
        checkOutput($sformatf("best_score run %0d", j), bus.best_score, exp_best[j]);
        checkOutput($sformatf("best_update run %0d", j), upd_seen, exp_upd[j]);
      end
      clear_on_finish = 1'b1;
      runAndCheck("clear with done", low_bits(9), '0, 1'b0, 9);
      clear_on_finish = 1'b0;
      checkOutput("best_score after clear", bus.best_score, 9);
      checkOutput("best_update after clear", upd_seen, 1);
    end
`endif

    r = rand_image();
    vecs[0].name = "equal";        vecs[0].img = r;                         vecs[0].tgt = r;  vecs[0].exp_score = 0;
    vecs[1].name = "inverse";      vecs[1].img = r;                         vecs[1].tgt = ~r; vecs[1].exp_score = 1024;
    vecs[2].name = "first chunk";  vecs[2].img = low_bits(32);              vecs[2].tgt = '0; vecs[2].exp_score = 32;
    vecs[3].name = "last chunk";   vecs[3].img = ~low_bits(Pixels - 32);    vecs[3].tgt = '0; vecs[3].exp_score = 32;
    vecs[4].name = "checkerboard"; vecs[4].img = {(Pixels / 2){2'b01}};     vecs[4].tgt = '0; vecs[4].exp_score = 512;
    vecs[5].name = "single bit";   vecs[5].img = '0; vecs[5].img[500] = 1'b1; vecs[5].tgt = '0; vecs[5].exp_score = 1;
    for (int v = 0; v < 6; v++)
      runAndCheck(vecs[v].name, vecs[v].img, vecs[v].tgt, 1'b0, vecs[v].exp_score);

    // Snapshot: image flipped right after the start edge must not matter.
    t = '0;
    r = '0;
    r[0] = 1'b1;
    r[Pixels-1] = 1'b1;
    runAndCheck("snapshot", r, t, 1'b1, 2);

    for (int k = 0; k < 8; k++) begin
      r = rand_image();
      t = r ^ (rand_image() & rand_image() & ((k % 2 == 0) ? rand_image() : '1));
      runAndCheck($sformatf("random %0d", k), r, t, 1'b0, model_score(r, t));
    end

    // Start held high: back-to-back runs every Chunks+1 edges.
    r = rand_image();
    t = rand_image();
    exp_s = model_score(r, t);
    bus.image  = r;
    bus.target = t;
    bus.start  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        done_pos.push_back(i);
        done_sc.push_back(longint'(bus.score));
      end
      if (i == Chunks + 1) checkOutput("b2b busy after restart", bus.busy, 1);
    end
    bus.start = 1'b0;
    checkOutput("b2b done count", done_pos.size(), 3);
    for (int j = 0; j < done_pos.size() && j < 3; j++) begin
      checkOutput($sformatf("b2b done pos %0d", j), done_pos[j], Chunks + j * (Chunks + 1));
      checkOutput($sformatf("b2b score %0d", j), done_sc[j], exp_s);
    end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!bus.busy && !bus.done) break;
    end

    // Start pulses while busy are ignored.
    r = rand_image();
    t = rand_image();
    exp_s = model_score(r, t);
    bus.image  = r;
    bus.target = t;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0;
    for (int n = 1; n <= 60; n++) begin
      bus.start = (n == 5) || (n == 20);
      if (bus.start) bus.image = rand_image();
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (n == 5) checkOutput("ignored start busy", bus.busy, 1);
      if (bus.done) begin
        dones++;
        checkOutput("ignored start score", bus.score, exp_s);
      end
    end
    checkOutput("ignored start done count", dones, 1);

    // Reset in the middle of a count: no done, score cleared, fresh run works.
    bus.image  = rand_image();
    bus.target = rand_image();
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    checkOutput("mid reset busy", bus.busy, 0);
    checkOutput("mid reset score", bus.score, 0);
    checkOutput("mid reset done", bus.done, 0);
    dones = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    checkOutput("mid reset no done", dones, 0);
    r = rand_image();
    t = rand_image();
    runAndCheck("after reset", r, t, 1'b0, model_score(r, t));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
